// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Entry widths follow the default DEPTH/WIDTH of instr_fetch_unit.
package ifu_pkg;
    localparam int IFU_DEPTH  = 128;
    localparam int IFU_WIDTH  = 32;
    localparam int IFU_ADDR_W = $clog2(IFU_DEPTH) + 2;
    localparam int PC_STEP    = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HALT
    } ifu_state_t;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_WIDTH-1:0]  instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} fetch entries; flush wins over push/pop.
// When empty the read port keeps presenting the last popped entry.
module fetch_buffer
    import ifu_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         full,
    output logic         empty
);
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    fetch_entry_t             mem_q [BUF_DEPTH];
    fetch_entry_t             mem_d [BUF_DEPTH];
    fetch_entry_t             last_q, last_d;
    logic         [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic         [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign rd_entry = empty ? last_q : mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            // A push into a full buffer is only issued alongside a pop, so it
            // overwrites the slot being read out this same cycle.
            if (push) begin
                mem_d[wr_ptr_q[IDX_W-1:0]] = wr_entry;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                last_d   = mem_q[rd_ptr_q[IDX_W-1:0]];
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, BOOT/FETCH/HALT control, redirect handling, fetch buffer.
// Define IFU_ALIGN_CHECK_EN to halt with fetch_fault on misaligned redirect targets.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH     = IFU_DEPTH,
    parameter int          WIDTH     = IFU_WIDTH,
    parameter int          BUF_DEPTH = 2,
    parameter int unsigned RESET_PC  = 0,
    localparam int         ADDR_W    = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [WIDTH-1:0]  out_instr,
    output logic              fetch_fault
);
    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_pc;
    logic              misalign;
    logic              push, pop, flush, full, empty, pop_ok;
    fetch_entry_t      wr_entry, rd_entry;

`ifdef IFU_ALIGN_CHECK_EN
    assign tgt_pc      = redirect_pc;
    assign misalign    = |redirect_pc[1:0];
    assign fetch_fault = (state_q == S_HALT);
`else
    assign tgt_pc      = redirect_pc & ~ADDR_W'(3);
    assign misalign    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign imem_addr = pc_q;
    assign out_valid = !empty;
    assign pop_ok    = out_valid && out_ready;
    assign wr_entry  = '{pc: pc_q, instr: imem_rdata};
    assign out_pc    = rd_entry.pc;
    assign out_instr = rd_entry.instr;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            // Any pop in flight this cycle is discarded along with the buffer.
            flush = 1'b1;
            if (misalign) begin
                state_d = S_HALT;
            end else begin
                pc_d    = tgt_pc;
                state_d = S_FETCH;
            end
        end else begin
            pop = pop_ok;
            case (state_q)
                S_BOOT:  state_d = S_FETCH;
                S_FETCH: begin
                    if (!full || pop_ok) begin
                        push = 1'b1;
                        pc_d = pc_q + ADDR_W'(PC_STEP);
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= ADDR_W'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .full     (full),
        .empty    (empty)
    );
endmodule
